// File: rtl/sram_arb.sv
// Two-requester arbiter/sequencer for the single-port sram32k data memory.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (port 0 wins).
module sram_arb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              req_valid_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_write_i,
    input  logic [63:0]             req_addr_i,
    input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
    output logic [1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    grant_o,
    output logic                    sram_cen_o,
    output logic                    sram_wen_o,
    output logic [ADDR_WIDTH-1:0]   sram_a_o,
    output logic [DATA_WIDTH-1:0]   sram_d_o,
    input  logic [DATA_WIDTH-1:0]   sram_q_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic                  write_q;
    logic [1:0]            rsp_valid_q;
    logic                  win;
    logic                  accept;
    logic [31:0]           win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic                  win_write;
    logic                  unused_addr_bits;
`ifdef SRAM_ARB_RR_EN
    logic                  last_grant;
`endif

    always_comb begin
`ifdef SRAM_ARB_RR_EN
        win = (&req_valid_i) ? ~last_grant : req_valid_i[1];
`else
        win = ~req_valid_i[0];
`endif
        // No accept while reset is sampled: the request would be discarded anyway.
        accept      = (state != ACCESS) && (|req_valid_i) && !rst_i;
        req_ready_o = '0;
        if (accept) req_ready_o[win] = 1'b1;
    end

    assign win_addr  = win ? req_addr_i[63:32] : req_addr_i[31:0];
    assign win_wdata = win ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
    assign win_write = win ? req_write_i[1] : req_write_i[0];
    assign unused_addr_bits = ^{win_addr[31:ADDR_WIDTH+2], win_addr[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            rsp_valid_q <= '0;
            grant_o     <= 1'b0;
            sram_cen_o  <= 1'b1;
            sram_wen_o  <= 1'b1;
            sram_a_o    <= '0;
            sram_d_o    <= '0;
`ifdef SRAM_ARB_RR_EN
            last_grant  <= 1'b1;
`endif
        end else begin
            rsp_valid_q <= '0;
            sram_cen_o  <= 1'b1;
            sram_wen_o  <= 1'b1;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state      <= ACCESS;
                        grant_o    <= win;
                        write_q    <= win_write;
                        sram_a_o   <= win_addr[ADDR_WIDTH+1:2];
                        sram_d_o   <= win_wdata;
                        sram_cen_o <= 1'b0;
                        sram_wen_o <= ~win_write;
`ifdef SRAM_ARB_RR_EN
                        last_grant <= win;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state                <= RESP;
                    rsp_valid_q[grant_o] <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response is suppressed in a cycle where reset is sampled, so an in-flight access never completes.
    assign rsp_valid_o = rsp_valid_q & {2{~rst_i}};
    assign rsp_rdata_o = (state == RESP && !write_q && !rst_i) ? sram_q_i : '0;

endmodule

// File: tb/tb_sram_arb.sv
// Scoreboard bench for sram_arb with a behavioural sram32k model.
module tb_sram_arb;
    localparam int DW = 32;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    wire  [1:0]    req_valid;
    logic [1:0]    req_ready;
    wire  [1:0]    req_write;
    wire  [63:0]   req_addr;
    wire  [2*DW-1:0] req_wdata;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          grant;
    logic          sram_cen, sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    always #5 clk = ~clk;

    sram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .grant_o(grant),
        .sram_cen_o(sram_cen), .sram_wen_o(sram_wen), .sram_a_o(sram_a),
        .sram_d_o(sram_d), .sram_q_i(sram_q)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_cen === 1'b0) begin
            if (sram_wen === 1'b0) mem[sram_a] <= sram_d;
            else                   sram_q      <= mem[sram_a];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        bit          chk_rsp;
        int          gap;
    } cmd_t;

    typedef struct { int port; logic [31:0] data; int cyc; } rsp_t;
    typedef struct { logic wen; logic [AW-1:0] a; logic [31:0] d; bit chk_d; int cyc; } acc_t;

    rsp_t rq[$];
    acc_t aq[$];
    int   acc_port[$];
    int   acc_cyc[$];

    function automatic cmd_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp, input bit chk_rsp, input int gap);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.exp = exp; c.chk_rsp = chk_rsp; c.gap = gap;
        return c;
    endfunction

    // Called at the negedge of the accept cycle: CEN expected one cycle later, response two.
    function automatic void note_accept(input int p, input cmd_t c);
        acc_t a;
        rsp_t r;
        acc_port.push_back(p);
        acc_cyc.push_back(cyc);
        a.wen = ~c.wr; a.a = c.addr[AW+1:2]; a.d = c.wdata; a.chk_d = c.wr; a.cyc = cyc + 1;
        aq.push_back(a);
        if (c.chk_rsp) begin
            r.port = p; r.data = c.exp; r.cyc = cyc + 2;
            rq.push_back(r);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_port
        cmd_t        cq[$];
        logic        v = 1'b0;
        logic        w = 1'b0;
        logic [31:0] a = '0;
        logic [31:0] d = '0;
        bit          busy = 1'b0;

        assign req_valid[g]           = v;
        assign req_write[g]           = w;
        assign req_addr[32*g +: 32]   = a;
        assign req_wdata[DW*g +: DW]  = d;

        initial begin : drv
            cmd_t c;
            int   t;
            forever begin
                if (cq.size() == 0) begin
                    v = 1'b0; busy = 1'b0;
                    @(posedge clk); #1;
                end else begin
                    c = cq.pop_front(); busy = 1'b1;
                    if (c.gap > 0) begin
                        v = 1'b0;
                        repeat (c.gap) @(posedge clk);
                        #1;
                    end
                    v = 1'b1; w = c.wr; a = c.addr; d = c.wdata;
                    t = 0;
                    do begin @(negedge clk); t++; end while (req_ready[g] !== 1'b1 && t < 200);
                    if (req_ready[g] === 1'b1) note_accept(g, c);
                    else chk("accept_timeout", 64'(t), 64'(0));
                    @(posedge clk); #1;
                end
            end
        end
    end

    task automatic push(input int p, input cmd_t c);
        if (p == 0) gen_port[0].cq.push_back(c);
        else        gen_port[1].cq.push_back(c);
    endtask

    // Monitor: invariants every cycle, scoreboard pops on CEN low and on response pulses.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
            if (sram_cen === 1'b0) chk("ready_in_access", 64'(req_ready), 64'(0));
        end
        while (aq.size() > 0 && aq[0].cyc < cyc) begin
            chk("sram_access_missing", 64'(cyc), 64'(aq[0].cyc));
            void'(aq.pop_front());
        end
        while (rq.size() > 0 && rq[0].cyc < cyc) begin
            chk("rsp_missing", 64'(cyc), 64'(rq[0].cyc));
            void'(rq.pop_front());
        end
        if (sram_cen === 1'b0) begin
            if (aq.size() == 0) chk("sram_access_unexpected", 64'(sram_cen), 64'(1));
            else begin
                acc_t e;
                e = aq.pop_front();
                chk("sram_cycle", 64'(cyc), 64'(e.cyc));
                chk("sram_wen", 64'(sram_wen), 64'(e.wen));
                chk("sram_a", 64'(sram_a), 64'(e.a));
                if (e.chk_d) chk("sram_d", 64'(sram_d), 64'(e.d));
            end
        end
        if (rsp_valid !== 2'b00) begin
            if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            else begin
                rsp_t e;
                e = rq.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_port", 64'(rsp_valid), 64'(2'b01 << e.port));
                chk("rsp_grant", 64'(grant), 64'(e.port));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while ((gen_port[0].cq.size() != 0 || gen_port[1].cq.size() != 0 || gen_port[0].busy ||
                gen_port[1].busy || rq.size() != 0 || aq.size() != 0) && t < 5000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 5000) chk("idle_timeout", 64'(t), 64'(0));
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_cen"}, 64'(sram_cen), 64'(1));
        chk({tag, "_wen"}, 64'(sram_wen), 64'(1));
        chk({tag, "_a"}, 64'(sram_a), 64'(0));
        chk({tag, "_d"}, 64'(sram_d), 64'(0));
    endtask

    // Issue one read on port 0 and hit reset either in ACCESS (late=0) or in RESP (late=1).
    task automatic reset_mid(input bit late, input string tag);
        int n, t;
        n = acc_port.size();
        push(0, mk(1'b0, 32'h40, '0, '0, 1'b0, 0));
        t = 0;
        while (acc_port.size() == n && t < 100) begin @(posedge clk); #1; t++; end
        chk({tag, "_accepted"}, 64'(acc_port.size()), 64'(n + 1));
        if (late) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(tag);
        wait_idle();
    endtask

    initial begin
        int n;
        logic [31:0] w;
        rst = 1'b1;
        for (int unsigned i = 0; i < 32; i++) mem[32'h100 + i] <= 32'hC0DE_0000 | (32'h100 + i);
        mem[16'h0010] <= 32'hDEAD_BEEF;
        mem[0]        <= 32'h0;
        @(posedge clk); @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        // Single read: byte 0x40 -> word 0x10.
        push(0, mk(1'b0, 32'h40, '0, 32'hDEAD_BEEF, 1'b1, 0));
        wait_idle();

        // Write then read at the top word.
        push(1, mk(1'b1, 32'h7FFC, 32'h1234_5678, 32'h0, 1'b1, 0));
        push(1, mk(1'b0, 32'h7FFC, '0, 32'h1234_5678, 1'b1, 0));
        wait_idle();

        // Address wrap: 0x8000 lands on word 0.
        push(0, mk(1'b1, 32'h8000, 32'hA5A5_A5A5, 32'h0, 1'b1, 0));
        push(0, mk(1'b0, 32'h0, '0, 32'hA5A5_A5A5, 1'b1, 0));
        wait_idle();
        chk("wrap_word0", 64'(mem[0]), 64'(32'hA5A5_A5A5));

        // Contention: both ports valid every cycle for 8 reads each.
        n = acc_port.size();
        for (int unsigned k = 0; k < 8; k++) begin
            push(0, mk(1'b0, (32'h100 + k) << 2, '0, 32'hC0DE_0000 | (32'h100 + k), 1'b1, 0));
            push(1, mk(1'b0, (32'h110 + k) << 2, '0, 32'hC0DE_0000 | (32'h110 + k), 1'b1, 0));
        end
        wait_idle();
        chk("cont_count", 64'(acc_port.size()), 64'(n + 16));
        for (int unsigned k = 0; k < 8; k++) begin
`ifdef SRAM_ARB_RR_EN
            // Last accept before this was port 0, so port 1 wins the opening tie.
            chk("cont_grant_rr", 64'(acc_port[n + k]), 64'((k + 1) % 2));
`else
            chk("cont_grant_fixed", 64'(acc_port[n + k]), 64'(0));
`endif
            if (k < 7) chk("cont_spacing", 64'(acc_cyc[n + k + 1] - acc_cyc[n + k]), 64'(2));
        end

        // Reset in ACCESS, then a tie must go to port 0.
        reset_mid(1'b0, "rst_access");
        n = acc_port.size();
        push(1, mk(1'b0, 32'h404, '0, 32'hC0DE_0101, 1'b1, 0));
        push(0, mk(1'b0, 32'h408, '0, 32'hC0DE_0102, 1'b1, 0));
        wait_idle();
        chk("post_rst_first", 64'(acc_port[n]), 64'(0));
        reset_mid(1'b1, "rst_resp");

        // Random traffic: writes above 0x200, reads of the preloaded region with junk address bits.
        for (int unsigned i = 0; i < 150; i++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    w = 32'h200 + 32'($urandom_range(0, 63));
                    push(p, mk(1'b1, {17'($urandom), w[12:0], 2'($urandom)}, $urandom, 32'h0, 1'b1,
                               int'($urandom_range(0, 3))));
                end else begin
                    w = 32'h100 + 32'($urandom_range(0, 31));
                    push(p, mk(1'b0, {17'($urandom), w[12:0], 2'($urandom)}, '0, 32'hC0DE_0000 | w,
                               1'b1, int'($urandom_range(0, 3))));
                end
            end
        end
        wait_idle();
        repeat (4) @(negedge clk);
        chk("rq_drained", 64'(rq.size()), 64'(0));
        chk("aq_drained", 64'(aq.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
